hamming_window_stage: RTL and testbench

- Consumes one frame from the upstream window buffer's read interface and multiplies each sample by a Hamming coefficient from a ROM.
- Zero-pads the frame up to FFT_SIZE and streams the result with valid/ready to the downstream FFT stage.
- Pulses frame_done_o when the last output of the frame is accepted; this pulse drives the window buffer's start_move.

---
 rtl/hamming_window_stage.sv | 277 +++++++++++++++++++++++++++
 tb/tb_hamming_window_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_window_stage.sv
// ---------------------------------------------------------------------------
// hamming_window_stage
//
// Reads one frame of FRAME_LEN signed samples from the window buffer and
// multiplies each by an unsigned Q0.16 Hamming coefficient. It then appends
// zeros up to FFT_SIZE outputs and streams the frame downstream with
// valid/ready. frame_done_o pulses one cycle after the last output is
// accepted. This pulse drives the window buffer's start_move.
//
// The coefficient image (the contents of hamming_306.hex) is supplied as the
// packed parameter COEF_ROM. Entry i sits at bits [i*COEF_WIDTH +: COEF_WIDTH].
//
// Optional build macro MFCC_WIN_ROUND_EN:
//   defined   -> round half-up and saturate to the signed WIDTH range
//   undefined -> truncate (arithmetic shift, floor) with no saturation
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start_i        frame start pulse, ignored unless IDLE
//   win_rd_en_o    read request to window buffer (READ state, not stalled)
//   win_data_i     window buffer sample, valid with win_valid_i
//   win_valid_i    window buffer has a sample to read
//   out_data_o     windowed sample
//   out_valid_o    output valid
//   out_ready_i    downstream ready
//   out_last_o     high with output index FFT_SIZE-1
//   out_index_o    index 0..FFT_SIZE-1 of the current output
//   busy_o         high whenever the FSM is not IDLE
//   frame_done_o   one-cycle pulse after the last output is accepted
// ---------------------------------------------------------------------------
module hamming_window_stage #(
  parameter int WIDTH      = 16,
  parameter int FRAME_LEN  = 306,
  parameter int FFT_SIZE   = 512,
  parameter int COEF_WIDTH = 16,
  parameter logic [FRAME_LEN*COEF_WIDTH-1:0] COEF_ROM = {FRAME_LEN{{COEF_WIDTH{1'b1}}}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             win_rd_en_o,
  input  logic [WIDTH-1:0] win_data_i,
  input  logic             win_valid_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_last_o,
  output logic [9:0]       out_index_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  localparam int IDX_W    = 10;
  localparam int PROD_W   = WIDTH + COEF_WIDTH + 1;
  localparam int ROM_BITS = FRAME_LEN * COEF_WIDTH;
  localparam int ROM_AW   = $clog2(ROM_BITS);
  localparam logic [IDX_W-1:0] LAST_READ = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(FFT_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    PAD   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         slot_cnt_q, slot_cnt_d;   // index of next slot entering P1
  logic                     p1_valid_q, p1_valid_d;
  logic signed [WIDTH-1:0]  p1_sample_q, p1_sample_d;
  logic [COEF_WIDTH-1:0]    p1_coef_q, p1_coef_d;
  logic [IDX_W-1:0]         p1_index_q, p1_index_d;
  logic                     p1_last_q, p1_last_d;
  logic                     out_valid_q, out_valid_d;
  logic [WIDTH-1:0]         out_data_q, out_data_d;
  logic [IDX_W-1:0]         out_index_q, out_index_d;
  logic                     out_last_q, out_last_d;
  logic                     busy_q, busy_d;
  logic                     frame_done_q, frame_done_d;

  logic                     stall_s;
  logic                     in_read_s;
  logic                     rd_en_s;
  logic                     inject_s;
  logic                     accept_last_s;
  logic [IDX_W-1:0]         rom_addr_s;
  logic [ROM_AW-1:0]        rom_base_s;
  logic [COEF_WIDTH-1:0]    rom_coef_s;
  logic signed [PROD_W-1:0] prod_s;
  logic [WIDTH-1:0]         win_res_s;

`ifdef MFCC_WIN_ROUND_EN
  localparam logic signed [PROD_W-1:0] ROUND_C =
    {{(PROD_W-COEF_WIDTH){1'b0}}, 1'b1, {(COEF_WIDTH-1){1'b0}}};
  localparam logic signed [PROD_W-1:0] SAT_MAX =
    {{(PROD_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN =
    {{(PROD_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  logic signed [PROD_W-1:0] shifted_s;
`endif

  // Handshake qualifiers and coefficient lookup (address held at 0 outside READ)
  always_comb begin
    stall_s       = out_valid_q && !out_ready_i;
    in_read_s     = (state_q == READ);
    rd_en_s       = in_read_s && !stall_s;
    accept_last_s = out_valid_q && out_ready_i && out_last_q;
    rom_addr_s    = {IDX_W{1'b0}};
    if (in_read_s) begin
      rom_addr_s = slot_cnt_q;
    end else begin
      rom_addr_s = {IDX_W{1'b0}};
    end
    rom_base_s = ROM_AW'(rom_addr_s) * ROM_AW'(COEF_WIDTH);
    rom_coef_s = COEF_ROM[rom_base_s +: COEF_WIDTH];
  end

  // Frame FSM: next state, slot counter and pipeline injection
  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    inject_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = READ;
          slot_cnt_d = {IDX_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (rd_en_s && win_valid_i) begin
          inject_s   = 1'b1;
          slot_cnt_d = slot_cnt_q + IDX_ONE;
          if (slot_cnt_q == LAST_READ) begin
            if (FFT_SIZE == FRAME_LEN) begin
              state_d = DRAIN;
            end else begin
              state_d = PAD;
            end
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = READ;
        end
      end
      PAD: begin
        if (!stall_s) begin
          inject_s   = 1'b1;
          slot_cnt_d = slot_cnt_q + IDX_ONE;
          if (slot_cnt_q == LAST_SLOT) begin
            state_d = DRAIN;
          end else begin
            state_d = PAD;
          end
        end else begin
          state_d = PAD;
        end
      end
      DRAIN: begin
        if (accept_last_s) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d    = IDLE;
        slot_cnt_d = {IDX_W{1'b0}};
      end
    endcase
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_q == DRAIN) && accept_last_s;
  end

  // Windowing arithmetic: signed sample times zero-extended Q0.16 coefficient
  always_comb begin
    prod_s = PROD_W'(p1_sample_q) * PROD_W'($signed({1'b0, p1_coef_q}));
`ifdef MFCC_WIN_ROUND_EN
    shifted_s = (prod_s + ROUND_C) >>> COEF_WIDTH;
    if (shifted_s > SAT_MAX) begin
      win_res_s = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (shifted_s < SAT_MIN) begin
      win_res_s = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      win_res_s = shifted_s[WIDTH-1:0];
    end
`else
    win_res_s = WIDTH'(prod_s >>> COEF_WIDTH);
`endif
  end

  // Two-stage pipeline; a stall freezes both stages, bubbles pass as invalid
  always_comb begin
    p1_valid_d  = p1_valid_q;
    p1_sample_d = p1_sample_q;
    p1_coef_d   = p1_coef_q;
    p1_index_d  = p1_index_q;
    p1_last_d   = p1_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    if (stall_s) begin
      p1_valid_d  = p1_valid_q;
      out_valid_d = out_valid_q;
    end else begin
      p1_valid_d = inject_s;
      if (inject_s) begin
        if (in_read_s) begin
          p1_sample_d = win_data_i;
          p1_coef_d   = rom_coef_s;
        end else begin
          p1_sample_d = {WIDTH{1'b0}};
          p1_coef_d   = {COEF_WIDTH{1'b0}};
        end
        p1_index_d = slot_cnt_q;
        p1_last_d  = (slot_cnt_q == LAST_SLOT);
      end else begin
        p1_last_d = 1'b0;
      end
      out_valid_d = p1_valid_q;
      if (p1_valid_q) begin
        out_data_d  = win_res_s;
        out_index_d = p1_index_q;
        out_last_d  = p1_last_q;
      end else begin
        out_last_d = 1'b0;
      end
    end
  end

  // State, counter and pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_cnt_q   <= {IDX_W{1'b0}};
      p1_valid_q   <= 1'b0;
      p1_sample_q  <= {WIDTH{1'b0}};
      p1_coef_q    <= {COEF_WIDTH{1'b0}};
      p1_index_q   <= {IDX_W{1'b0}};
      p1_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= {WIDTH{1'b0}};
      out_index_q  <= {IDX_W{1'b0}};
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      p1_valid_q   <= p1_valid_d;
      p1_sample_q  <= p1_sample_d;
      p1_coef_q    <= p1_coef_d;
      p1_index_q   <= p1_index_d;
      p1_last_q    <= p1_last_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_index_q  <= out_index_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_rd_en_o  = rd_en_s;
  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign out_last_o   = out_last_q;
  assign out_index_o  = out_index_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_hamming_window_stage.sv
module tb_hamming_window_stage;

  // Coefficients 0..9 are 0.5 (0x8000); the rest are 1.0 (0xFFFF)
  localparam logic [306*16-1:0] TB_ROM = {{296{16'hFFFF}}, {10{16'h8000}}};

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        win_rd_en_o;
  logic [15:0] win_data_i;
  logic        win_valid_i;
  logic [15:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        out_last_o;
  logic [9:0]  out_index_o;
  logic        busy_o;
  logic        frame_done_o;

  int nchecks = 0;
  int nerr    = 0;
  logic [15:0] samp [306];

  hamming_window_stage #(
    .WIDTH(16), .FRAME_LEN(306), .FFT_SIZE(512), .COEF_WIDTH(16), .COEF_ROM(TB_ROM)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .win_rd_en_o(win_rd_en_o),
    .win_data_i(win_data_i), .win_valid_i(win_valid_i), .out_data_o(out_data_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_last_o(out_last_o),
    .out_index_o(out_index_o), .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] coef_of(input int i);
    return (i < 10) ? 16'h8000 : 16'hFFFF;
  endfunction

  function automatic logic [15:0] model_out(input logic [15:0] s, input logic [15:0] c);
    longint p;
    p = longint'($signed(s)) * longint'(c);
`ifdef MFCC_WIN_ROUND_EN
    p = (p + 64'sd32768) >>> 16;
    if (p > 64'sd32767) p = 64'sd32767;
    else if (p < -64'sd32768) p = -64'sd32768;
`else
    p = p >>> 16;
`endif
    return p[15:0];
  endfunction

  // Drives one frame and scoreboards it. bp enables random valid and the
  // 1,0,0,1 ready pattern; extra_start re-pulses start_i mid-frame;
  // abort_after >= 0 returns right after that output index is accepted.
  task automatic stream_frame(input bit bp, input bit extra_start, input int abort_after);
    int sent, got, cyc, first_rd, first_val, done_cnt, done_cyc, last_acc;
    bit prev_stall, stall;
    logic [15:0] pd, expd;
    logic [9:0] pi;
    logic pl;
    logic [15:0] hand [3];
    hand[0] = 16'h2000;
    hand[1] = 16'hC000;
`ifdef MFCC_WIN_ROUND_EN
    hand[2] = 16'h0001;
`else
    hand[2] = 16'h0000;
`endif
    sent = 0; got = 0; cyc = 0; first_rd = -1; first_val = -1;
    done_cnt = 0; done_cyc = -1; last_acc = -1; prev_stall = 1'b0;
    pd = 16'h0000; pi = 10'd0; pl = 1'b0;
    for (int i = 0; i < 306; i++) begin
      samp[i] = (i == 0) ? 16'h4000 : (i == 1) ? 16'h8000 : (i == 2) ? 16'h0001 : 16'($urandom);
    end
    while (got < 512 && cyc < 6000 && !(abort_after >= 0 && got > abort_after)) begin
      @(posedge clk); #1;
      start_i     = (cyc == 0) || (extra_start && (cyc == 50 || cyc == 400));
      win_valid_i = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      win_data_i  = (sent < 306) ? samp[sent] : 16'($urandom);
      out_ready_i = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      #1;
      if (prev_stall) begin
        nchecks++;
        if (out_valid_o !== 1'b1 || out_data_o !== pd || out_index_o !== pi || out_last_o !== pl) begin
          nerr++;
          $display("FAIL stall_hold: got v=%b d=%h i=%0d l=%b, required v=1 d=%h i=%0d l=%b",
                   out_valid_o, out_data_o, out_index_o, out_last_o, pd, pi, pl);
        end
      end
      stall = (out_valid_o === 1'b1) && !out_ready_i;
      if (stall) begin
        nchecks++;
        if (win_rd_en_o !== 1'b0) begin
          nerr++;
          $display("FAIL rd_en_in_stall: got %b, required 0", win_rd_en_o);
        end
      end
      if (win_rd_en_o === 1'b1 && win_valid_i) begin
        if (first_rd < 0) first_rd = cyc;
        sent++;
      end
      if (out_valid_o === 1'b1 && first_val < 0) first_val = cyc;
      if (out_valid_o === 1'b1 && out_ready_i) begin
        expd = (got < 306) ? model_out(samp[got], coef_of(got)) : 16'h0000;
        nchecks++;
        if (out_index_o !== 10'(got)) begin
          nerr++;
          $display("FAIL out_index: got %0d, required %0d", out_index_o, got);
        end
        nchecks++;
        if (out_data_o !== expd) begin
          nerr++;
          $display("FAIL out_data[%0d]: got %h, required %h", got, out_data_o, expd);
        end
        nchecks++;
        if (out_last_o !== (got == 511)) begin
          nerr++;
          $display("FAIL out_last[%0d]: got %b, required %b", got, out_last_o, (got == 511));
        end
        if (got < 3) begin
          nchecks++;
          if (out_data_o !== hand[got]) begin
            nerr++;
            $display("FAIL arith[%0d]: got %h, required %h", got, out_data_o, hand[got]);
          end
        end
        if (got == 511) last_acc = cyc;
        got++;
      end
      if (frame_done_o === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = stall;
      pd = out_data_o; pi = out_index_o; pl = out_last_o;
      cyc++;
    end
    start_i = 1'b0;
    if (abort_after < 0) begin
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        win_valid_i = 1'b0;
        #1;
        if (frame_done_o === 1'b1) begin
          done_cnt++;
          done_cyc = cyc;
        end
        cyc++;
      end
      nchecks++;
      if (got != 512) begin
        nerr++;
        $display("FAIL frame_outputs: got %0d outputs in %0d cycles, required 512", got, cyc);
      end
      nchecks++;
      if (sent != 306) begin
        nerr++;
        $display("FAIL read_count: got %0d, required 306", sent);
      end
      nchecks++;
      if (first_val - first_rd != 2) begin
        nerr++;
        $display("FAIL latency: got %0d, required 2", first_val - first_rd);
      end
      nchecks++;
      if (done_cnt != 1 || done_cyc != last_acc + 1) begin
        nerr++;
        $display("FAIL frame_done: got count %0d at cycle %0d, required 1 at cycle %0d",
                 done_cnt, done_cyc, last_acc + 1);
      end
      nchecks++;
      if (busy_o !== 1'b0) begin
        nerr++;
        $display("FAIL busy_after_frame: got %b, required 0", busy_o);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b0; win_valid_i = 1'b0; win_data_i = 16'h0000; out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nchecks++; if (out_valid_o !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b, required 0", out_valid_o); end
    nchecks++; if (out_data_o !== 16'h0000) begin nerr++; $display("FAIL rst_data: got %h, required 0000", out_data_o); end
    nchecks++; if (out_index_o !== 10'd0) begin nerr++; $display("FAIL rst_index: got %0d, required 0", out_index_o); end
    nchecks++; if (out_last_o !== 1'b0) begin nerr++; $display("FAIL rst_last: got %b, required 0", out_last_o); end
    nchecks++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b, required 0", busy_o); end
    nchecks++; if (frame_done_o !== 1'b0) begin nerr++; $display("FAIL rst_done: got %b, required 0", frame_done_o); end
    nchecks++; if (win_rd_en_o !== 1'b0) begin nerr++; $display("FAIL rst_rd_en: got %b, required 0", win_rd_en_o); end
    rst = 1'b0; out_ready_i = 1'b1; win_valid_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nchecks++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || win_rd_en_o !== 1'b0) begin
      nerr++;
      $display("FAIL idle_no_start: got busy=%b valid=%b rd_en=%b, required 0 0 0",
               busy_o, out_valid_o, win_rd_en_o);
    end
  endtask

  task automatic test_frame_count;
    stream_frame(1'b0, 1'b0, -1);
  endtask

  task automatic test_backpressure;
    stream_frame(1'b1, 1'b1, -1);
  endtask

  task automatic test_reset_midframe;
    int vcnt, dcnt;
    stream_frame(1'b0, 1'b0, 100);
    rst = 1'b1;
    #1;
    nchecks++;
    if (out_valid_o !== 1'b0 || out_data_o !== 16'h0000 || out_index_o !== 10'd0 ||
        busy_o !== 1'b0 || win_rd_en_o !== 1'b0) begin
      nerr++;
      $display("FAIL midrst_outputs: got v=%b d=%h i=%0d busy=%b rd=%b, required all 0",
               out_valid_o, out_data_o, out_index_o, busy_o, win_rd_en_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vcnt = 0; dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #2;
      if (out_valid_o === 1'b1) vcnt++;
      if (frame_done_o === 1'b1) dcnt++;
    end
    nchecks++;
    if (vcnt != 0) begin nerr++; $display("FAIL midrst_no_output: got %0d valid cycles, required 0", vcnt); end
    nchecks++;
    if (dcnt != 0) begin nerr++; $display("FAIL midrst_no_done: got %0d pulses, required 0", dcnt); end
    stream_frame(1'b0, 1'b0, -1);
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    win_valid_i = 1'b0;
    win_data_i = 16'h0000;
    out_ready_i = 1'b0;
    test_reset();
    test_frame_count();
    test_backpressure();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
